// File: rtl/huffman_dec.sv
// Prefix-code bitstream unpacker: splits MSB-first packed words into codewords of the form
// k ones, a zero, one payload bit (length k+2); seven leading ones is flagged as illegal.
module huffman_dec #(
  parameter int unsigned W = 8,
  parameter int unsigned C = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_in,
  input  logic         en_in,
  output logic         in_rdy,
  input  logic         flush,
  output logic [W-1:0] d_out,
  output logic [C-1:0] w_out,
  output logic         en_out,
  output logic         err
);

  localparam int unsigned BW   = 2 * W;
  localparam int unsigned CntW = $clog2(BW + 1);

  logic [BW-1:0]   buf_q, buf_d, buf_mid;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_mid;
  logic [W-1:0]    d_out_q;
  logic [C-1:0]    w_out_q;
  logic            en_out_q, err_q;

  logic [C-1:0]    ones, len;
  logic            run, illegal, dec, accept;
  logic [W-1:0]    mask, dec_word;

  // Leading ones over the zero-padded buffer; a run reaching cnt makes len exceed cnt.
  always_comb begin
    ones = '0;
    run  = 1'b1;
    for (int i = 0; i < W - 1; i++) begin
      if (run && buf_q[BW-1-i]) ones = ones + C'(1);
      else                      run  = 1'b0;
    end
    illegal = (ones == C'(W - 1));
    len     = illegal ? C'(W) : ones + C'(2);
  end

  assign dec      = (cnt_q >= CntW'(len));
  assign mask     = ~({W{1'b1}} >> len);
  assign dec_word = buf_q[BW-1 -: W] & mask;
  assign in_rdy   = (cnt_q <= CntW'(W));
  assign accept   = en_in & in_rdy & ~flush;

  // Consume first, then append the new word just below the remaining valid bits.
  always_comb begin
    buf_mid = buf_q;
    cnt_mid = cnt_q;
    if (dec) begin
      buf_mid = buf_q << len;
      cnt_mid = cnt_q - CntW'(len);
    end
    buf_d = buf_mid;
    cnt_d = cnt_mid;
    if (accept) begin
      buf_d = buf_mid | ({d_in, {W{1'b0}}} >> cnt_mid);
      cnt_d = cnt_mid + CntW'(W);
    end
    if (flush) begin
      buf_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q    <= '0;
      cnt_q    <= '0;
      d_out_q  <= '0;
      w_out_q  <= '0;
      en_out_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      en_out_q <= dec & ~flush;
      if (dec && !flush) begin
        d_out_q <= dec_word;
        w_out_q <= len;
        err_q   <= illegal;
      end
    end
  end

  assign d_out  = d_out_q;
  assign w_out  = w_out_q;
  assign en_out = en_out_q;
  assign err    = err_q;

endmodule

// File: tb/tb_huffman_dec.sv
// Bench for huffman_dec: directed scenarios then random traffic, checked against a
// bit-queue model that parses the accepted stream one codeword per cycle.
module tb_huffman_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d_in;
  logic       en_in;
  logic       in_rdy;
  logic       flush;
  logic [7:0] d_out;
  logic [3:0] w_out;
  logic       en_out;
  logic       err;

  huffman_dec #(.W(8), .C(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .d_in   (d_in),
    .en_in  (en_in),
    .in_rdy (in_rdy),
    .flush  (flush),
    .d_out  (d_out),
    .w_out  (w_out),
    .en_out (en_out),
    .err    (err)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         n_pulse = 0;
  bit         q[$];
  logic [7:0] last_d = 8'h00;
  logic [3:0] last_w = 4'h0;
  logic       last_acc = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict the edge from the bit queue, check after the edge.
  task automatic step(input logic e, input logic [7:0] d, input logic fl);
    int         k;
    int         len;
    logic [7:0] val;
    logic       exp_en;
    logic       exp_err;
    logic       exp_rdy;
    en_in = e;
    d_in  = d;
    flush = fl;
    #1;
    exp_rdy = (q.size() <= 8);
    chk("in_rdy", 16'(in_rdy), 16'(exp_rdy));
    exp_en  = 1'b0;
    exp_err = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      k = 0;
      while (k < 7 && k < q.size() && q[k]) k++;
      len = (k == 7) ? 8 : k + 2;
      if (q.size() >= len) begin
        val = 8'h00;
        for (int i = 0; i < len; i++) val[7-i] = q[i];
        repeat (len) void'(q.pop_front());
        exp_en  = 1'b1;
        exp_err = (k == 7);
        last_d  = val;
        last_w  = 4'(len);
      end
      if (e && exp_rdy) for (int i = 7; i >= 0; i--) q.push_back(d[i]);
    end
    last_acc = e && exp_rdy && !fl;
    @(posedge clk);
    #1;
    if (en_out === 1'b1) n_pulse++;
    chk("en_out", 16'(en_out), 16'(exp_en));
    chk("d_out", 16'(d_out), 16'(last_d));
    chk("w_out", 16'(w_out), 16'(last_w));
    if (exp_en) chk("err", 16'(err), 16'(exp_err));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  // Hold the word until it is taken, bounded.
  task automatic send(input logic [7:0] d);
    int tries = 0;
    do begin
      step(1'b1, d, 1'b0);
      tries++;
    end while (!last_acc && tries < 20);
    chk("send_timeout", 16'(last_acc), 16'd1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_d_out", 16'(d_out), 16'h0);
    chk("rst_w_out", 16'(w_out), 16'h0);
    chk("rst_en_out", 16'(en_out), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_in_rdy", 16'(in_rdy), 16'h1);
  endtask

  initial begin
    int         base;
    logic       pv;
    logic [7:0] pw;
    logic       fl;
    rst   = 1'b0;
    en_in = 1'b0;
    d_in  = 8'h00;
    flush = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 0x11: four 2-bit codes
    base = n_pulse;
    send(8'h11);
    idle(6);
    chk("t1_pulses", 16'(n_pulse - base), 16'd4);

    // alternating 3-bit codes across word boundaries
    base = n_pulse;
    send(8'h96);
    send(8'h59);
    send(8'h65);
    idle(8);
    chk("t2_pulses", 16'(n_pulse - base), 16'd8);

    // longest legal codes, then the illegal prefix
    send(8'hFC);
    send(8'hFD);
    idle(3);
    send(8'hFE);
    idle(3);

    // back-pressure with en_in held high
    base = n_pulse;
    send(8'h11);
    send(8'h11);
    send(8'h11);
    idle(12);
    chk("t4_pulses", 16'(n_pulse - base), 16'd12);

    // 5-bit code plus padding, then flush
    send(8'hE0);
    idle(1);
    step(1'b0, 8'h00, 1'b1);
    idle(3);
    chk("flush_rdy", 16'(in_rdy), 16'h1);

    // partial code then asynchronous reset mid-stream
    send(8'hF8);
    idle(2);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    q.delete();
    last_d = 8'h00;
    last_w = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    base = n_pulse;
    send(8'h11);
    idle(6);
    chk("t6_pulses", 16'(n_pulse - base), 16'd4);

    // random traffic with occasional flush
    pv = 1'b0;
    pw = 8'h00;
    for (int i = 0; i < 800; i++) begin
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv = 1'b1;
        pw = 8'($urandom);
      end
      fl = ($urandom_range(0, 39) == 0);
      step(pv, pw, fl);
      if (last_acc) pv = 1'b0;
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
